// File: rtl/key_cmd_queue_if.sv
// Event/command bundle between the keyboard decoder side, the command queue
// and its consumer.
interface key_cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             key_valid;
  logic [8:0]       last_change;
  logic [511:0]     key_down;
  logic             cmd_ready;
  logic             cmd_valid;
  logic [3:0]       cmd;
  logic [3:0]       held;
  logic [LVL_W-1:0] level;
  logic [7:0]       drop_cnt;

  modport master (
    output key_valid, last_change, key_down, cmd_ready,
    input  cmd_valid, cmd, held, level, drop_cnt
  );

  modport slave (
    input  key_valid, last_change, key_down, cmd_ready,
    output cmd_valid, cmd, held, level, drop_cnt
  );
endinterface

// File: rtl/key_cmd_queue.sv
// Maps PS/2 key events to 4-bit game commands, auto-repeats held movement
// keys and buffers commands in a small valid/ready FIFO.
module key_cmd_queue #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  key_cmd_queue_if.slave  bus
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [3:0] NONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        held_q, held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        drop_q, drop_d;
  logic [3:0]        mem_q [DEPTH];

  logic [3:0] code, push_code;
  logic       key_is_down, press, rel_held, tick, push_req;
  logic       empty, full, pop, push;
  logic       unused_inputs;

  function automatic logic [3:0] map_code(input logic [7:0] sc);
    case (sc)
      8'h59:   return 4'h0;
      8'h69:   return 4'h1;
      8'h72:   return 4'h2;
      8'h7A:   return 4'h3;
      8'h73:   return 4'h5;
      8'h1D:   return 4'h6;
      8'h1C:   return 4'h8;
      8'h1B:   return 4'h7;
      8'h23:   return 4'h9;
      8'h29:   return 4'hA;
      default: return NONE;
    endcase
  endfunction

  // Only the low 256 scan codes can ever be mapped.
  assign unused_inputs = ^{bus.last_change[8], bus.key_down[511:256]};

  always_comb begin
    code        = map_code(bus.last_change[7:0]);
    key_is_down = bus.key_down[{1'b0, bus.last_change[7:0]}];
    press       = bus.key_valid & key_is_down & (code != NONE);
    rel_held    = bus.key_valid & ~key_is_down & (code != NONE) & (code == held_q);
    tick        = ((state_q == S_DELAY)  && (cnt_q == CNT_W'(REPEAT_DELAY - 1))) ||
                  ((state_q == S_REPEAT) && (cnt_q == CNT_W'(REPEAT_PERIOD - 1)));
  end

  // Repeat scheduler: a press beats a same-cycle tick, a release of the held key cancels it.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    cnt_d     = cnt_q;
    push_req  = 1'b0;
    push_code = code;
    if (state_q != S_IDLE) cnt_d = cnt_q + CNT_W'(1);
    if (press) begin
      push_req = 1'b1;
      if (code != 4'h0 && code != 4'hA) begin
        state_d = S_DELAY;
        held_d  = code;
        cnt_d   = '0;
      end else if (tick) begin
        cnt_d = '0;
      end
    end else if (rel_held) begin
      state_d = S_IDLE;
      held_d  = NONE;
      cnt_d   = '0;
    end else if (tick) begin
      push_req  = 1'b1;
      push_code = held_q;
      state_d   = S_REPEAT;
      cnt_d     = '0;
    end
  end

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop      = ~empty & bus.cmd_ready;
    // Full FIFO still accepts a push when the head leaves in the same cycle.
    push     = push_req & (~full | pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    drop_d   = drop_q;
    if (push_req && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      held_q   <= NONE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (push && wr_ptr_q[ADDR_W-1:0] == ADDR_W'(gi)) mem_q[gi] <= push_code;
      end
    end
  endgenerate

  assign bus.cmd_valid = ~empty;
  assign bus.cmd       = empty ? NONE : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.held      = held_q;
  assign bus.level     = wr_ptr_q - rd_ptr_q;
  assign bus.drop_cnt  = drop_q;
endmodule
